// File: rtl/tratar_cmd.sv
// tratar_cmd: command executor behind the UART command decoder.
// Accepts {opcode, operand} over a valid/ready handshake and executes it
// against a small register bank addressed by a selection pointer.
module tratar_cmd #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [3:0]          instrucao,
  input  logic [DATA_W-1:0]   dado,
  output logic [DATA_W-1:0]   dec7Seg,
  output logic [4+DATA_W-1:0] led,
  output logic                clear,
  output logic                erro,
  output logic                carry
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StExec  = 2'd1;
  localparam logic [1:0] StSweep = 2'd2;

  localparam logic [3:0] OpNop    = 4'd0;
  localparam logic [3:0] OpClear  = 4'd1;
  localparam logic [3:0] OpLoad   = 4'd2;
  localparam logic [3:0] OpSelect = 4'd3;
  localparam logic [3:0] OpShow   = 4'd4;
  localparam logic [3:0] OpAdd    = 4'd5;
  localparam logic [3:0] OpNext   = 4'd6;
  localparam logic [3:0] OpClrErr = 4'd7;

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  logic [1:0]          state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [3:0]          op_q, op_d;
  logic [DATA_W-1:0]   arg_q, arg_d;
  logic [DATA_W-1:0]   dec_q, dec_d;
  logic [4+DATA_W-1:0] led_q, led_d;
  logic                erro_q, erro_d;
  logic                carry_q, carry_d;
  logic [DATA_W-1:0]   bank_q [DEPTH];
  logic [DATA_W-1:0]   bank_d [DEPTH];
  logic [DATA_W:0]     sum;

  assign cmd_ready = (state_q == StIdle);
  assign clear     = (state_q == StSweep);
  assign dec7Seg   = dec_q;
  assign led       = led_q;
  assign erro      = erro_q;
  assign carry     = carry_q;

  // Add at DATA_W+1 bits so the top bit is the carry out.
  assign sum = {1'b0, bank_q[ptr_q]} + {1'b0, arg_q};

  // Next-state: handshake, opcode execution and clear sweep.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    op_d    = op_q;
    arg_d   = arg_q;
    dec_d   = dec_q;
    led_d   = led_q;
    erro_d  = erro_q;
    carry_d = carry_q;
    for (int i = 0; i < int'(DEPTH); i++) bank_d[i] = bank_q[i];

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d    = instrucao;
          arg_d   = dado;
          led_d   = {instrucao, dado};
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StIdle;
        case (op_q)
          OpNop: ;
          OpClear: begin
            ptr_d   = '0;
            idx_d   = '0;
            state_d = StSweep;
          end
          OpLoad: bank_d[ptr_q] = arg_q;
          OpSelect: begin
            // Compare at 32 bits so narrow operands are zero-extended.
            if (32'(arg_q) < 32'(DEPTH)) ptr_d = ADDR_W'(arg_q);
            else                         erro_d = 1'b1;
          end
          OpShow: dec_d = bank_q[ptr_q];
          OpAdd: begin
            bank_d[ptr_q] = sum[DATA_W-1:0];
            carry_d       = sum[DATA_W];
          end
          OpNext:   ptr_d = ptr_q + 1'b1;
          OpClrErr: begin
            erro_d  = 1'b0;
            carry_d = 1'b0;
          end
          default: erro_d = 1'b1;
        endcase
      end
      StSweep: begin
        bank_d[idx_q] = '0;
        idx_d         = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          dec_d   = '0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      op_q    <= '0;
      arg_q   <= '0;
      dec_q   <= '0;
      led_q   <= '0;
      erro_q  <= 1'b0;
      carry_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) bank_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
      dec_q   <= dec_d;
      led_q   <= led_d;
      erro_q  <= erro_d;
      carry_q <= carry_d;
      for (int i = 0; i < int'(DEPTH); i++) bank_q[i] <= bank_d[i];
    end
  end

endmodule
